gates7_checker: RTL and testbench

- Hardware result checker for the seven-function gate block. It is the receiving end of that block's stimulus/monitor path.
- Accepts beats of {a, b, seven function outputs} over a valid/ready handshake.
- Recomputes the expected results, counts mismatches and records the first failing vector.
- Reports pass/fail after a fixed number of vectors. Used in on-board self-test and as a synthesizable monitor beside the gate block.

---
 rtl/gates7_checker_if.sv | 11 +
 rtl/gates7_checker.sv | 121 ++++++++++++
 tb/tb_gates7_checker.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gates7_checker_if.sv
// Beat handshake between the gate-block monitor path (master) and gates7_checker (slave).
interface gates7_checker_if;
   logic       in_valid;
   logic       in_ready;
   logic       a;
   logic       b;
   logic [6:0] f;

   modport master (output in_valid, a, b, f, input in_ready);
   modport slave  (input in_valid, a, b, f, output in_ready);
endinterface

// File: rtl/gates7_checker.sv
// Result checker for the seven-function gate block: two-stage compare pipeline, error counting, first-failure capture.
// Optional macro GATES7_CHECKER_STOP_ON_ERR_EN ends the run on the first mismatching beat.
module gates7_checker #(
   parameter int N_VECTORS = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   gates7_checker_if.slave  bus,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [6:0]       first_err_mask
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_VECTORS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;

   logic             ready;
   logic [CNT_W-1:0] acc_cnt;
   logic             vld_p0;
   logic             a_p0, b_p0;
   logic [6:0]       f_p0;
   logic [6:0]       mask_p0;
   logic             accept, clear, stop_err;

   function automatic logic [6:0] expected(input logic x, input logic y);
      return {x & y, x | y, ~x, ~(x & y), ~(x | y), x ^ y, ~(x ^ y)};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign bus.in_ready = ready;
   assign accept       = bus.in_valid && ready;
   assign clear        = start && (state != RUN);
   assign mask_p0      = f_p0 ^ expected(a_p0, b_p0);
   assign busy         = (state == RUN);
   assign done         = (state == DONE);
   assign pass         = done && (err_count == '0);

`ifdef GATES7_CHECKER_STOP_ON_ERR_EN
   assign stop_err = vld_p0 && (mask_p0 != 7'd0);
`else
   assign stop_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (vld_p0 && ((vec_count == LAST) || stop_err)) state_nx = DONE;
         DONE:    if (start) state_nx = RUN;
         default: state_nx = IDLE;
      endcase
   end

   // stage p0: capture the accepted beat (data only, no reset)
   always_ff @(posedge clk) begin
      if (accept) begin
         a_p0 <= bus.a;
         b_p0 <= bus.b;
         f_p0 <= bus.f;
      end
   end

   // stage p1: compare registered beat, update counters and first-failure record
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready          <= 1'b0;
         acc_cnt        <= '0;
         vld_p0         <= 1'b0;
         vec_count      <= '0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_mask <= 7'd0;
      end else if (clear) begin
         ready          <= 1'b1;
         acc_cnt        <= '0;
         vld_p0         <= 1'b0;
         vec_count      <= '0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_mask <= 7'd0;
      end else begin
         vld_p0 <= accept;
         if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
            ready   <= (acc_cnt != LAST);
         end
         if (vld_p0) begin
            vec_count <= vec_count + 1'b1;
            if (mask_p0 != 7'd0) begin
               err_count <= sat_inc(err_count);
               // err_count saturates and never wraps, so zero means no mismatch yet this run
               if (err_count == '0) begin
                  first_err_idx  <= vec_count;
                  first_err_mask <= mask_p0;
               end
            end
         end
         if (stop_err) begin
            ready  <= 1'b0;
            vld_p0 <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_gates7_checker.sv
// Scoreboard bench for gates7_checker: expected masks queued at accept, popped as vec_count advances.
module tb_gates7_checker;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       busy, done, pass;
   logic [7:0] err_count, vec_count, first_err_idx;
   logic [6:0] first_err_mask;

   int checks = 0;
   int errors = 0;

   logic [6:0] q[$];
   logic [7:0] m_err = 8'd0, m_idx = 8'd0, last_vec = 8'd0;
   logic [6:0] m_mask = 7'd0;
   logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

   always #5 clk = ~clk;

   gates7_checker_if bus ();

   gates7_checker #(.N_VECTORS(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus.slave),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .vec_count(vec_count),
      .first_err_idx(first_err_idx), .first_err_mask(first_err_mask)
   );

   function automatic logic [6:0] model_f(input logic x, input logic y);
      return {x & y, x | y, ~x, ~(x & y), ~(x | y), x ^ y, ~(x ^ y)};
   endfunction

   // scoreboard monitor: one pop per compared beat
   always @(negedge clk) begin
      if (rst_n && (vec_count == last_vec + 8'd1)) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: vec_count=%0d with no queued beat", vec_count);
         end else begin
            logic [6:0] m;
            m = q.pop_front();
            if (m != 7'd0) begin
               if (m_err == 8'd0) begin
                  m_idx  = last_vec;
                  m_mask = m;
               end
               if (m_err != 8'hff) m_err = m_err + 8'd1;
            end
            if ({err_count, first_err_idx, first_err_mask} !== {m_err, m_idx, m_mask}) begin
               errors++;
               $display("FAIL sb_compare: got err=%0d idx=%0d mask=%b want err=%0d idx=%0d mask=%b",
                        err_count, first_err_idx, first_err_mask, m_err, m_idx, m_mask);
            end
         end
      end
      last_vec = vec_count;
   end

   task automatic clear_model();
      q.delete();
      m_err  = 8'd0;
      m_idx  = 8'd0;
      m_mask = 7'd0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      bus.in_valid = 1'b0;
      clear_model();
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_beat(input int idx, input logic [6:0] flip, input int gaps);
      int n;
      repeat (gaps) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = ab_tab[idx][1];
      bus.b = ab_tab[idx][0];
      bus.f = model_f(ab_tab[idx][1], ab_tab[idx][0]) ^ flip;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: beat %0d in_ready=%b want 1", idx, bus.in_ready);
      end else begin
         q.push_back(bus.f ^ model_f(bus.a, bus.b));
      end
      @(posedge clk);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%b want 1", done);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.a = 1'b0;
      bus.b = 1'b0;
      bus.f = 7'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.in_ready, busy, done, pass, err_count, vec_count, first_err_idx, first_err_mask} !== 35'd0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b busy=%b done=%b pass=%b err=%0d vec=%0d idx=%0d mask=%b want all 0",
                  bus.in_ready, busy, done, pass, err_count, vec_count, first_err_idx, first_err_mask);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_clean_run();
      do_start();
      for (int i = 0; i < 4; i++) send_beat(i, 7'd0, 0);
      wait_done();
      checks++;
      if ({pass, err_count, vec_count, first_err_mask} !== {1'b1, 8'd0, 8'd4, 7'd0}) begin
         errors++;
         $display("FAIL clean_final: pass=%b err=%0d vec=%0d mask=%b want 1 0 4 0000000",
                  pass, err_count, vec_count, first_err_mask);
      end
   endtask

   task automatic test_error_run();
      logic [7:0] want_vec;
`ifdef GATES7_CHECKER_STOP_ON_ERR_EN
      want_vec = 8'd3;
`else
      want_vec = 8'd4;
`endif
      do_start();
      for (int i = 0; i < 4; i++) send_beat(i, (i == 2) ? 7'b0000010 : 7'd0, 0);
      wait_done();
      checks++;
      if ({pass, err_count, first_err_idx, first_err_mask} !== {1'b0, 8'd1, 8'd2, 7'b0000010}) begin
         errors++;
         $display("FAIL error_final: pass=%b err=%0d idx=%0d mask=%b want 0 1 2 0000010",
                  pass, err_count, first_err_idx, first_err_mask);
      end
      checks++;
      if (vec_count !== want_vec) begin
         errors++;
         $display("FAIL error_vec: vec=%0d want %0d", vec_count, want_vec);
      end
   endtask

   task automatic test_gaps();
      do_start();
      send_beat(0, 7'd0, 0);
      send_beat(1, 7'd0, 2);
      send_beat(2, 7'd0, 1);
      send_beat(3, 7'd0, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL gaps_done_early: done=%b want 0", done);
      end
      @(negedge clk);
      checks++;
      if ({done, busy, pass, err_count, vec_count} !== {1'b1, 1'b0, 1'b1, 8'd0, 8'd4}) begin
         errors++;
         $display("FAIL gaps_final: done=%b busy=%b pass=%b err=%0d vec=%0d want 1 0 1 0 4",
                  done, busy, pass, err_count, vec_count);
      end
   endtask

   task automatic test_back_to_back();
      int  cnt;
      logic seen;
      do_start();
      cnt  = 0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (cnt == 4 && !seen) begin
            seen = 1'b1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_after_last: in_ready=%b want 0", bus.in_ready);
            end
         end
         bus.in_valid = 1'b1;
         bus.a = ab_tab[cnt % 4][1];
         bus.b = ab_tab[cnt % 4][0];
         bus.f = model_f(bus.a, bus.b);
         if (bus.in_ready) begin
            q.push_back(7'd0);
            cnt++;
         end
      end
      wait_done();
      checks++;
      if (cnt != 4 || vec_count !== 8'd4 || pass !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back: accepted=%0d vec=%0d pass=%b want 4 4 1", cnt, vec_count, pass);
      end
   endtask

   task automatic test_mid_reset();
      do_start();
      send_beat(0, 7'd0, 0);
      send_beat(1, 7'b1000000, 0);
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      clear_model();
      checks++;
      if ({bus.in_ready, busy, done, pass, err_count, vec_count, first_err_idx, first_err_mask} !== 35'd0) begin
         errors++;
         $display("FAIL mid_reset: rdy=%b busy=%b done=%b pass=%b err=%0d vec=%0d idx=%0d mask=%b want all 0",
                  bus.in_ready, busy, done, pass, err_count, vec_count, first_err_idx, first_err_mask);
      end
      test_clean_run();
   endtask

   task automatic test_restart();
      test_error_run();
      do_start();
      checks++;
      if ({busy, err_count, vec_count, first_err_idx, first_err_mask} !== {1'b1, 8'd0, 8'd0, 8'd0, 7'd0}) begin
         errors++;
         $display("FAIL restart_clear: busy=%b err=%0d vec=%0d idx=%0d mask=%b want 1 0 0 0 0",
                  busy, err_count, vec_count, first_err_idx, first_err_mask);
      end
      send_beat(0, 7'd0, 0);
      send_beat(1, 7'd0, 0);
      @(negedge clk);
      start = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, vec_count} !== {1'b1, 8'd2}) begin
         errors++;
         $display("FAIL start_in_run: busy=%b vec=%0d want 1 2", busy, vec_count);
      end
      send_beat(2, 7'd0, 0);
      send_beat(3, 7'd0, 0);
      wait_done();
      checks++;
      if ({pass, err_count, vec_count} !== {1'b1, 8'd0, 8'd4}) begin
         errors++;
         $display("FAIL restart_final: pass=%b err=%0d vec=%0d want 1 0 4", pass, err_count, vec_count);
      end
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_error_run();
      test_gaps();
      test_back_to_back();
      test_mid_reset();
      test_restart();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
